// File: rtl/top_pkg.sv
// Shared types and constants for the crypto-core
// sequencing controller.
package top_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD_KEY = 4'd1,
    S_KDF      = 4'd2,
    S_WAIT_MSG = 4'd3,
    S_LOAD_MSG = 4'd4,
    S_AES      = 4'd5,
    S_MAC      = 4'd6,
    S_OUT_C    = 4'd7,
    S_GAP      = 4'd8,
    S_OUT_M    = 4'd9
  } state_e;

  localparam int SALT_BYTES   = 16;
  localparam int MSG_BYTES    = 16;
  localparam int CIPHER_BYTES = 16;
  localparam int MAC_BYTES    = 32;

  localparam logic AES_ENC = 1'b0;
  localparam logic AES_DEC = 1'b1;

endpackage

// File: rtl/out_serializer.sv
// Byte serializer: parallel 256-bit load, LSB byte
// first, registered data/valid and a last-byte flag.
module out_serializer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [255:0] data_i,
  input  logic [5:0]   len_i,
  output logic [7:0]   data_o,
  output logic         valid_o,
  output logic         done_o
);

  logic [255:0] buf_q;
  logic [5:0]   cnt_q;
  logic [5:0]   len_q;
  logic [7:0]   data_q;
  logic         valid_q;

  // done marks the cycle in which the last byte is on data_o
  assign done_o  = valid_q && (cnt_q == len_q);
  assign data_o  = data_q;
  assign valid_o = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      buf_q   <= data_i;
      len_q   <= len_i;
      cnt_q   <= 6'd1;
      data_q  <= data_i[7:0];
      valid_q <= 1'b1;
    end else if (valid_q) begin
      if (done_o) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        cnt_q   <= '0;
      end else begin
        data_q <= buf_q[{cnt_q[4:0], 3'b000} +: 8];
        cnt_q  <= cnt_q + 6'd1;
      end
    end
  end

endmodule

// File: rtl/top_ctrl.sv
// Sequencing controller: key load, KDF, message load,
// AES, HMAC, then cipher/MAC byte bursts to the host.
module top_ctrl
  import top_pkg::*;
#(
  parameter int PW_BYTES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            i_data,
  input  logic                  i_start,
  input  logic                  i_mode,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  output logic                  o_ien,
  output logic [127:0]          o_salt,
  output logic [8*PW_BYTES-1:0] o_pw,
  output logic [127:0]          o_msg,
  output logic                  o_mode,
  output logic                  kdf_start,
  input  logic                  kdf_done,
  output logic                  aes_start,
  input  logic                  aes_done,
  input  logic [127:0]          aes_cipher,
  output logic                  mac_start,
  input  logic                  mac_done,
  input  logic [255:0]          mac_value
);

  localparam int PW_W = 8 * PW_BYTES;
  // counter runs one behind the byte index in load states
  localparam logic [5:0] SALT_LAST = 6'(SALT_BYTES - 2);
  localparam logic [5:0] KEY_LAST  = 6'(SALT_BYTES + PW_BYTES - 2);
  localparam logic [5:0] MSG_LAST  = 6'(MSG_BYTES - 2);

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [127:0]   salt_q, salt_d;
  logic [PW_W-1:0] pw_q, pw_d;
  logic [127:0]   msg_q, msg_d;
  logic [127:0]   cipher_q, cipher_d;
  logic [255:0]   mac_q, mac_d;
  logic           mode_q, mode_d;
  logic           kdf_q, aes_q, macs_q;

  logic           ser_load;
  logic [255:0]   ser_data;
  logic [5:0]     ser_len;
  logic           ser_done;

  always_comb begin
    state_d  = state_q;
    salt_d   = salt_q;
    pw_d     = pw_q;
    msg_d    = msg_q;
    cipher_d = cipher_q;
    mac_d    = mac_q;
    mode_d   = mode_q;
    ser_load = 1'b0;
    ser_data = '0;
    ser_len  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_LOAD_KEY;
          salt_d   = {120'b0, i_data};
          pw_d     = '0;
          msg_d    = '0;
          cipher_d = '0;
          mac_d    = '0;
          mode_d   = i_mode;
        end
      end
      S_LOAD_KEY: begin
        if (!i_start) begin
          state_d = S_IDLE;
          salt_d  = '0;
          pw_d    = '0;
        end else begin
          if (cnt_q <= SALT_LAST)
            salt_d = {salt_q[119:0], i_data};
          else
            pw_d = (pw_q << 8) | PW_W'(i_data);
          if (cnt_q == KEY_LAST)
            state_d = S_KDF;
        end
      end
      S_KDF: begin
        if (kdf_done && !kdf_q)
          state_d = S_WAIT_MSG;
      end
      S_WAIT_MSG: begin
        if (i_start) begin
          state_d = S_LOAD_MSG;
          msg_d   = {120'b0, i_data};
        end
      end
      S_LOAD_MSG: begin
        if (!i_start) begin
          state_d = S_WAIT_MSG;
          msg_d   = '0;
        end else begin
          msg_d = {msg_q[119:0], i_data};
          if (cnt_q == MSG_LAST)
            state_d = S_AES;
        end
      end
      S_AES: begin
        if (aes_done && !aes_q) begin
          state_d  = S_MAC;
          cipher_d = aes_cipher;
        end
      end
      S_MAC: begin
        if (mac_done && !macs_q) begin
          state_d  = S_OUT_C;
          mac_d    = mac_value;
          ser_load = 1'b1;
          ser_data = {128'b0, cipher_q};
          ser_len  = 6'(CIPHER_BYTES);
        end
      end
      S_OUT_C: begin
        if (ser_done)
          state_d = S_GAP;
      end
      S_GAP: begin
        state_d  = S_OUT_M;
        ser_load = 1'b1;
        ser_data = mac_q;
        ser_len  = 6'(MAC_BYTES);
      end
      S_OUT_M: begin
        if (ser_done)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == S_LOAD_KEY ||
         state_q == S_LOAD_MSG))
      cnt_d = cnt_q + 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      salt_q   <= '0;
      pw_q     <= '0;
      msg_q    <= '0;
      cipher_q <= '0;
      mac_q    <= '0;
      mode_q   <= AES_ENC;
      kdf_q    <= 1'b0;
      aes_q    <= 1'b0;
      macs_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      salt_q   <= salt_d;
      pw_q     <= pw_d;
      msg_q    <= msg_d;
      cipher_q <= cipher_d;
      mac_q    <= mac_d;
      mode_q   <= mode_d;
      kdf_q    <= (state_d == S_KDF) && (state_q != S_KDF);
      aes_q    <= (state_d == S_AES) && (state_q != S_AES);
      macs_q   <= (state_d == S_MAC) && (state_q != S_MAC);
    end
  end

  out_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ser_load),
    .data_i  (ser_data),
    .len_i   (ser_len),
    .data_o  (o_data),
    .valid_o (o_valid),
    .done_o  (ser_done)
  );

  assign o_ien     = (state_q == S_KDF);
  assign o_salt    = salt_q;
  assign o_pw      = pw_q;
  assign o_msg     = msg_q;
  assign o_mode    = mode_q;
  assign kdf_start = kdf_q;
  assign aes_start = aes_q;
  assign mac_start = macs_q;

endmodule

// File: doc/top_ctrl.md
# top_ctrl

Top-level sequencing controller for the AES/SHA3 crypto core. It accepts the host byte stream: salt and password first, then the message. It runs key derivation (PBKDF on the Keccak engine), AES and HMAC in a fixed order through start/done handshakes. It then serializes the 16-byte cipher and the 32-byte HMAC back to the host. It sits between the `Top` byte-wide pins and the engines, and owns every engine start pulse.

## Interface
- `PW_BYTES`, 15, password length in bytes (1..32)
- `clk` in 1, single clock, all logic on posedge
- `rst_n` in 1, asynchronous active-low reset
- `i_data` in 8, host input byte
- `i_start` in 1, host byte-valid; high for consecutive bytes of one transfer
- `i_mode` in 1, AES direction, 0 = encrypt, 1 = decrypt; latched on the first salt byte
- `o_data` out 8, output byte (registered)
- `o_valid` out 1, high while `o_data` carries a burst byte
- `o_ien` out 1, high while key derivation is running; its falling edge grants the message transfer
- `o_salt` out 128, assembled salt; first byte received lands in [127:120]
- `o_pw` out 8*PW_BYTES, assembled password, first byte in MSB
- `o_msg` out 128, assembled message, first byte in MSB
- `o_mode` out 1, latched `i_mode`
- `kdf_start`/`kdf_done` out/in 1, one-cycle start pulse and done pulse to/from the PBKDF engine
- `aes_start`/`aes_done` out/in 1, AES handshake
- `aes_cipher` in 128, AES result, valid when `aes_done`
- `mac_start`/`mac_done` out/in 1, HMAC handshake (MAC computed over cipher)
- `mac_value` in 256, HMAC result, valid when `mac_done`

## Operation
- States: IDLE, LOAD_KEY, KDF, WAIT_MSG, LOAD_MSG, AES, MAC, OUT_C, GAP, OUT_M.
- IDLE: when `i_start`=1, capture the byte as salt byte 0, latch `i_mode`, and go to LOAD_KEY.
- LOAD_KEY: shift one byte per cycle while `i_start`=1. Bytes 0..15 go to the salt and bytes 16..15+PW_BYTES go to the password. After the last byte, go to KDF.
- LOAD_KEY abort: if `i_start` drops before the last byte, discard the partial data, clear the counter and return to IDLE.
- KDF: pulse `kdf_start` on entry and hold `o_ien`=1. On `kdf_done`, go to WAIT_MSG; `o_ien` falls.
- WAIT_MSG: `i_start`=1 captures message byte 0 and moves to LOAD_MSG.
- LOAD_MSG: takes 16 bytes. If `i_start` drops early, discard the partial message and return to WAIT_MSG.
- AES: pulse `aes_start` on entry. On `aes_done`, register `aes_cipher` and go to MAC.
- MAC: pulse `mac_start` on entry. On `mac_done`, register `mac_value` and go to OUT_C.
- OUT_C: 16 cycles with `o_valid`=1. Byte k is cipher[8k+7:8k], LSB byte first.
- GAP: exactly 1 cycle with `o_valid`=0, so the host sees a new rising edge.
- OUT_M: 32 cycles, byte k is mac[8k+7:8k]. Then go to IDLE. Registered salt, password, message and results persist until the next salt byte.
- Byte counter is 6 bits and clears on every state change.
- `i_start` in KDF, AES, MAC, OUT_C, GAP or OUT_M is ignored.
- Done pulses arriving in any state other than their own are ignored.
- A done pulse arriving in the same cycle as its start pulse is not accepted; done is sampled from the cycle after start onward.

## Timing
- Reset values: all outputs 0; internal registers 0; state IDLE.
- Reset mid-operation aborts immediately, with no output flush.
- Input capture: a byte is sampled at the posedge where `i_start`=1. The host drives data at negedge.
- `kdf_start` pulses in the cycle after the final password byte is captured. `o_ien` rises in that same cycle.
- `o_ien` falls in the cycle after `kdf_done` is sampled.
- `aes_start` pulses 1 cycle after the 16th message byte is captured.
- `mac_start` pulses 1 cycle after `aes_done`.
- `o_valid` rises 1 cycle after `mac_done`. `o_valid` and `o_data` change together, registered.
- Total output window: 16 + 1 + 32 = 49 cycles.

## Structure
- Put in `top_pkg`:
  - state enum
  - `SALT_BYTES`=16, `MSG_BYTES`=16, `CIPHER_BYTES`=16, `MAC_BYTES`=32
  - `AES_ENC`=0, `AES_DEC`=1
- Sub-module `out_serializer`: parallel 256-bit load, byte select by counter, length input (16 or 32), and a burst-done flag. The FSM stays in `top_ctrl`.

## Test plan
- Reset, then salt 00..0F + password 10..1E with engine done pulses after 5 cycles:
  - `o_salt`=000102..0F, `o_pw`=1011..1E, `kdf_start` one cycle after byte 30.
  - `o_ien` high 6 cycles then falls.
- Message 20..2F, `aes_cipher`=A0..AF, `mac_value`=B0..CF:
  - `o_data` sequence AF..A0 (LSB byte A0 first? no: byte 0 = [7:0]).
  - `o_valid` high 16 cycles, low 1 cycle, high 32 cycles, then IDLE.
- `i_mode`=1 on the first salt byte, toggled to 0 mid-load → `o_mode` stays 1.
- `i_start` dropped after 20 key bytes → return to IDLE with no `kdf_start`; a full retry then passes.
- Spurious `aes_done` during KDF and `i_start` pulses during OUT_M → no state change and no captured bytes.
- `rst_n` low during OUT_C byte 7 → all outputs 0 asynchronously; a fresh full transaction then completes correctly.
